// File: rtl/enclave_cmd_pkg.sv
// Shared state encoding, header layout and size defaults for the enclave command path.
package enclave_cmd_pkg;

    localparam int DATA_W_DEF       = 32;
    localparam int MAX_OPERANDS_DEF = 8;
    localparam int MAX_RESULTS_DEF  = 4;
    localparam int OPCODE_W_DEF     = 8;

    // Header word layout: [31:24] opcode, [19:16] operand count, [11:8] result count.
    localparam int HDR_OPC_LSB = 24;
    localparam int HDR_N_LSB   = 16;
    localparam int HDR_M_LSB   = 8;
    localparam int HDR_CNT_W   = 4;

    typedef enum logic [2:0] {
        IDLE,
        COLLECT,
        ISSUE,
        WAIT_RES,
        DRAIN
    } state_t;

    typedef struct packed {
        logic [OPCODE_W_DEF-1:0] opcode;
        logic [HDR_CNT_W-1:0]    n;
        logic [HDR_CNT_W-1:0]    m;
    } hdr_t;

endpackage

// File: rtl/res_buffer.sv
// Result word store: filled in order up to depth words, then read back in order.
// Latency: write lands next cycle; rd_data is a combinational view of slot ridx.
// Backpressure: writes are dropped once full; clr rewinds both indexes.
module res_buffer #(
    parameter int  DATA_W = 32,
    parameter int  DEPTH  = 4,
    localparam int CW     = $clog2(DEPTH + 1),
    localparam int AW     = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clr,
    input  logic [CW-1:0]     depth,
    input  logic              wr_en,
    input  logic [DATA_W-1:0] wr_data,
    output logic              wr_last,
    output logic              full,
    input  logic              rd_adv,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_last
);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [CW-1:0]     widx;
    logic [CW-1:0]     ridx;

    always_ff @(posedge clk) begin
        if (rst) begin
            widx <= '0;
            ridx <= '0;
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else if (clr) begin
            widx <= '0;
            ridx <= '0;
        end else begin
            if (wr_en && !full) begin
                mem[widx[AW-1:0]] <= wr_data;
                widx              <= widx + CW'(1);
            end
            if (rd_adv) ridx <= ridx + CW'(1);
        end
    end

    assign full    = (widx == depth);
    assign wr_last = (widx + CW'(1) == depth);
    assign rd_last = (ridx + CW'(1) == depth);
    assign rd_data = mem[ridx[AW-1:0]];

endmodule

// File: rtl/cmd_assembler.sv
// Builds a header + operand command from controller write words, hands it to the core, returns results per host read.
// Latency: op_valid 1 cycle after the last operand is accepted; out_valid 1 cycle after the m-th result.
// Backpressure: op_valid holds until op_ready; out_valid holds until out_ack; words arriving mid-command are dropped as overruns.
module cmd_assembler
    import enclave_cmd_pkg::*;
#(
    parameter int DATA_W       = DATA_W_DEF,
    parameter int MAX_OPERANDS = MAX_OPERANDS_DEF,
    parameter int MAX_RESULTS  = MAX_RESULTS_DEF,
    parameter int OPCODE_W     = OPCODE_W_DEF
) (
    input  logic                           wb_clk_i,
    input  logic                           wb_rst_i,
    input  logic                           in_valid,
    input  logic [DATA_W-1:0]              in_data,
    input  logic                           config_en,
    output logic                           op_valid,
    output logic [OPCODE_W-1:0]            op_code,
    output logic [3:0]                     op_count,
    output logic [MAX_OPERANDS*DATA_W-1:0] op_operands,
    input  logic                           op_ready,
    input  logic                           res_valid,
    input  logic [DATA_W-1:0]              res_data,
    output logic                           res_ready,
    output logic                           out_valid,
    output logic [DATA_W-1:0]              out_data,
    input  logic                           out_ack,
    output logic                           busy,
    output logic                           error
);

    localparam int OAW = (MAX_OPERANDS > 1) ? $clog2(MAX_OPERANDS) : 1;
    localparam int RCW = $clog2(MAX_RESULTS + 1);

    state_t            state;
    logic              in_valid_q;
    logic              accept;
    hdr_t              hdr;
    logic              hdr_ok;
    logic              take_hdr;
    logic [3:0]        idx;
    logic [RCW-1:0]    m_q;
    logic [DATA_W-1:0] opnd_q [MAX_OPERANDS];

    logic              res_wr;
    logic              res_wr_last;
    logic              res_full;
    logic              res_rd_last;

    // A held strobe is one word: only the low-to-high transition is taken.
    assign accept = in_valid && !in_valid_q;

    assign hdr = '{opcode: in_data[HDR_OPC_LSB +: OPCODE_W_DEF],
                   n:      in_data[HDR_N_LSB +: HDR_CNT_W],
                   m:      in_data[HDR_M_LSB +: HDR_CNT_W]};

    assign hdr_ok = (hdr.n != '0) && (hdr.n <= HDR_CNT_W'(MAX_OPERANDS)) &&
                    (hdr.m != '0) && (hdr.m <= HDR_CNT_W'(MAX_RESULTS));

    assign take_hdr = accept && config_en && hdr_ok && (state == IDLE || state == COLLECT);

    assign res_wr = res_valid && res_ready && !res_full;
    assign busy   = (state != IDLE);

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state      <= IDLE;
            in_valid_q <= 1'b0;
            idx        <= '0;
            m_q        <= '0;
            op_valid   <= 1'b0;
            op_code    <= '0;
            op_count   <= '0;
            res_ready  <= 1'b0;
            out_valid  <= 1'b0;
            error      <= 1'b0;
            for (int i = 0; i < MAX_OPERANDS; i++) opnd_q[i] <= '0;
        end else begin
            in_valid_q <= in_valid;

            if (accept && (state == ISSUE || state == WAIT_RES || state == DRAIN))
                error <= 1'b1;

            // Clearing every slot here is what keeps unused operand slots at zero.
            if (take_hdr) begin
                op_code  <= hdr.opcode;
                op_count <= hdr.n;
                m_q      <= hdr.m[RCW-1:0];
                idx      <= '0;
                for (int i = 0; i < MAX_OPERANDS; i++) opnd_q[i] <= '0;
            end

            case (state)
                IDLE: begin
                    if (accept) begin
                        if (take_hdr) begin
                            error <= 1'b0;
                            state <= COLLECT;
                        end else begin
                            error <= 1'b1;
                        end
                    end
                end
                COLLECT: begin
                    if (accept) begin
                        if (config_en) begin
                            error <= 1'b1;
                            if (!hdr_ok) state <= IDLE;
                        end else begin
                            opnd_q[idx[OAW-1:0]] <= in_data;
                            idx                  <= idx + 4'd1;
                            if (idx + 4'd1 == op_count) begin
                                op_valid <= 1'b1;
                                state    <= ISSUE;
                            end
                        end
                    end
                end
                ISSUE: begin
                    if (op_ready) begin
                        op_valid  <= 1'b0;
                        res_ready <= 1'b1;
                        state     <= WAIT_RES;
                    end
                end
                WAIT_RES: begin
                    if (res_wr && res_wr_last) begin
                        res_ready <= 1'b0;
                        out_valid <= 1'b1;
                        state     <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (out_ack && res_rd_last) begin
                        out_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    for (genvar g = 0; g < MAX_OPERANDS; g++) begin : g_pack
        assign op_operands[g*DATA_W +: DATA_W] = opnd_q[g];
    end

    res_buffer #(
        .DATA_W (DATA_W),
        .DEPTH  (MAX_RESULTS)
    ) u_res_buffer (
        .clk     (wb_clk_i),
        .rst     (wb_rst_i),
        .clr     (state == ISSUE),
        .depth   (m_q),
        .wr_en   (res_wr),
        .wr_data (res_data),
        .wr_last (res_wr_last),
        .full    (res_full),
        .rd_adv  (out_valid && out_ack),
        .rd_data (out_data),
        .rd_last (res_rd_last)
    );

endmodule

// File: tb/tb_cmd_assembler.sv
// Directed scoreboard bench for cmd_assembler: stimulus pushes expected commands/results, a monitor pops them on handshakes.
module tb_cmd_assembler;

    logic         wb_clk_i = 1'b0;
    logic         wb_rst_i;
    logic         in_valid;
    logic [31:0]  in_data;
    logic         config_en;
    logic         op_valid;
    logic [7:0]   op_code;
    logic [3:0]   op_count;
    logic [255:0] op_operands;
    logic         op_ready;
    logic         res_valid;
    logic [31:0]  res_data;
    logic         res_ready;
    logic         out_valid;
    logic [31:0]  out_data;
    logic         out_ack;
    logic         busy;
    logic         error;

    cmd_assembler dut (
        .wb_clk_i    (wb_clk_i),
        .wb_rst_i    (wb_rst_i),
        .in_valid    (in_valid),
        .in_data     (in_data),
        .config_en   (config_en),
        .op_valid    (op_valid),
        .op_code     (op_code),
        .op_count    (op_count),
        .op_operands (op_operands),
        .op_ready    (op_ready),
        .res_valid   (res_valid),
        .res_data    (res_data),
        .res_ready   (res_ready),
        .out_valid   (out_valid),
        .out_data    (out_data),
        .out_ack     (out_ack),
        .busy        (busy),
        .error       (error)
    );

    always #5 wb_clk_i = ~wb_clk_i;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic [7:0]   code;
        logic [3:0]   cnt;
        logic [255:0] ops;
    } cmd_t;

    cmd_t        exp_cmd[$];
    logic [31:0] exp_out[$];

    task automatic check(input string name, input logic [319:0] act, input logic [319:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: compares on every handshake and tracks op_* stability while stalled.
    cmd_t         mc;
    logic [31:0]  mo;
    logic [267:0] snap;
    logic         snap_live = 1'b0;

    always @(negedge wb_clk_i) begin
        if (wb_rst_i !== 1'b0) begin
            snap_live = 1'b0;
        end else begin
            if (op_valid) begin
                if (snap_live) check("op_stable", {op_code, op_count, op_operands}, snap);
                snap      = {op_code, op_count, op_operands};
                snap_live = !op_ready;
                if (op_ready) begin
                    if (exp_cmd.size() == 0) begin
                        checks++;
                        failures++;
                        $display("FAIL op_unexpected: got op_code %0h, no command expected", op_code);
                    end else begin
                        mc = exp_cmd.pop_front();
                        check("op_code", op_code, mc.code);
                        check("op_count", op_count, mc.cnt);
                        check("op_operands", op_operands, mc.ops);
                    end
                end
            end else begin
                snap_live = 1'b0;
            end
            if (out_valid && out_ack) begin
                if (exp_out.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL out_unexpected: got out_data %0h, no word expected", out_data);
                end else begin
                    mo = exp_out.pop_front();
                    check("out_data", out_data, mo);
                end
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge wb_clk_i);
        #1;
    endtask

    task automatic send_word(input logic [31:0] d, input logic cfg, input int hold);
        in_data   = d;
        config_en = cfg;
        in_valid  = 1'b1;
        tick(hold);
        in_valid  = 1'b0;
        config_en = 1'b0;
        tick(1);
    endtask

    task automatic wait_op();
        for (int i = 0; i < 50 && !op_valid; i++) tick(1);
        check("op_valid_seen", op_valid, 1);
    endtask

    task automatic accept_op(input int stall);
        wait_op();
        if (stall > 0) tick(stall);
        op_ready = 1'b1;
        tick(1);
        op_ready = 1'b0;
    endtask

    task automatic send_results(input logic [31:0] w [4], input int m);
        for (int i = 0; i < 50 && !res_ready; i++) tick(1);
        check("res_ready_seen", res_ready, 1);
        for (int i = 0; i < m; i++) begin
            res_valid = 1'b1;
            res_data  = w[i];
            tick(1);
        end
        res_valid = 1'b0;
        check("out_latency", out_valid, 1);
    endtask

    task automatic ack(input int k);
        for (int j = 0; j < k; j++) begin
            for (int i = 0; i < 50 && !out_valid; i++) tick(1);
            check("out_valid_seen", out_valid, 1);
            out_ack = 1'b1;
            tick(1);
            out_ack = 1'b0;
            tick(1);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        wb_rst_i  = 1'b1;
        in_valid  = 1'b0;
        in_data   = '0;
        config_en = 1'b0;
        op_ready  = 1'b0;
        res_valid = 1'b0;
        res_data  = '0;
        out_ack   = 1'b0;
        tick(3);
        wb_rst_i = 1'b0;

        // Reset state
        check("rst_op_valid", op_valid, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_error", error, 0);
        check("rst_res_ready", res_ready, 0);
        check("rst_op_count", op_count, 0);
        check("rst_out_data", out_data, 0);

        // Basic command: op 0x0A, n=2, m=1
        exp_cmd.push_back('{8'h0A, 4'd2, {192'h0, 32'h22222222, 32'h11111111}});
        exp_out.push_back(32'hDEADBEEF);
        send_word(32'h0A020100, 1'b1, 1);
        check("t1_busy", busy, 1);
        send_word(32'h11111111, 1'b0, 1);
        check("t1_no_early_issue", op_valid, 0);
        in_data  = 32'h22222222;
        in_valid = 1'b1;
        tick(1);
        check("t1_issue_latency", op_valid, 1);
        in_valid = 1'b0;
        tick(1);
        accept_op(0);
        send_results('{32'hDEADBEEF, 32'h0, 32'h0, 32'h0}, 1);
        ack(1);
        check("t1_idle_busy", busy, 0);
        check("t1_idle_out_valid", out_valid, 0);

        // Words held high for 3 cycles: op 0x05, n=3, m=2
        exp_cmd.push_back('{8'h05, 4'd3, {160'h0, 32'hA0000003, 32'hA0000002, 32'hA0000001}});
        exp_out.push_back(32'h00000100);
        exp_out.push_back(32'h00000200);
        send_word(32'h05030200, 1'b1, 3);
        send_word(32'hA0000001, 1'b0, 3);
        send_word(32'hA0000002, 1'b0, 3);
        check("t2_not_issued", op_valid, 0);
        check("t2_busy", busy, 1);
        check("t2_error", error, 0);
        send_word(32'hA0000003, 1'b0, 3);
        check("t2_issued", op_valid, 1);
        accept_op(0);
        send_results('{32'h00000100, 32'h00000200, 32'h0, 32'h0}, 2);
        ack(2);
        check("t2_done", busy, 0);

        // Invalid headers: n=0, n=9, m=5
        send_word(32'h07000100, 1'b1, 1);
        check("t3_n0_error", error, 1);
        check("t3_n0_busy", busy, 0);
        send_word(32'h07090100, 1'b1, 1);
        check("t3_n9_error", error, 1);
        check("t3_n9_busy", busy, 0);
        send_word(32'h07010500, 1'b1, 1);
        check("t3_m5_error", error, 1);
        check("t3_m5_busy", busy, 0);
        check("t3_no_op", op_valid, 0);
        exp_cmd.push_back('{8'h07, 4'd1, {224'h0, 32'h77777777}});
        exp_out.push_back(32'h00000007);
        send_word(32'h07010100, 1'b1, 1);
        check("t3_valid_clears", error, 0);
        check("t3_valid_busy", busy, 1);
        send_word(32'h77777777, 1'b0, 1);
        accept_op(0);
        send_results('{32'h00000007, 32'h0, 32'h0, 32'h0}, 1);
        ack(1);
        send_word(32'h55555555, 1'b0, 1);
        check("t3_idle_data_error", error, 1);
        check("t3_idle_data_busy", busy, 0);

        // Abort: new header after 1 of 3 operands
        send_word(32'h0C030100, 1'b1, 1);
        check("t4_first_hdr_error", error, 0);
        send_word(32'hBAD00001, 1'b0, 1);
        exp_cmd.push_back('{8'h0D, 4'd2, {192'h0, 32'h0D000002, 32'h0D000001}});
        exp_out.push_back(32'hD0D0D0D0);
        send_word(32'h0D020100, 1'b1, 1);
        check("t4_abort_error", error, 1);
        check("t4_abort_busy", busy, 1);
        send_word(32'h0D000001, 1'b0, 1);
        check("t4_not_issued", op_valid, 0);
        send_word(32'h0D000002, 1'b0, 1);
        accept_op(0);
        send_results('{32'hD0D0D0D0, 32'h0, 32'h0, 32'h0}, 1);
        ack(1);
        check("t4_error_sticky", error, 1);

        // Stall op_ready for 10 cycles with an overrun word during ISSUE
        exp_cmd.push_back('{8'h0E, 4'd4, {128'h0, 32'hE0000004, 32'hE0000003, 32'hE0000002, 32'hE0000001}});
        exp_out.push_back(32'h0000EEEE);
        send_word(32'h0E040100, 1'b1, 1);
        check("t5_hdr_clears", error, 0);
        send_word(32'hE0000001, 1'b0, 1);
        send_word(32'hE0000002, 1'b0, 1);
        send_word(32'hE0000003, 1'b0, 1);
        send_word(32'hE0000004, 1'b0, 1);
        wait_op();
        tick(3);
        send_word(32'hFFFFFFFF, 1'b0, 1);
        check("t5_overrun_error", error, 1);
        check("t5_still_valid", op_valid, 1);
        tick(5);
        op_ready = 1'b1;
        tick(1);
        op_ready = 1'b0;
        send_results('{32'h0000EEEE, 32'h0, 32'h0, 32'h0}, 1);
        ack(1);

        // m=4 results, overrun in DRAIN, reset after the 2nd ack
        exp_cmd.push_back('{8'h01, 4'd1, {224'h0, 32'h00000042}});
        exp_out.push_back(32'h00000001);
        exp_out.push_back(32'h00000002);
        send_word(32'h01010400, 1'b1, 1);
        check("t6_hdr_clears", error, 0);
        send_word(32'h00000042, 1'b0, 1);
        accept_op(0);
        send_results('{32'h00000001, 32'h00000002, 32'h00000003, 32'h00000004}, 4);
        send_word(32'h12345678, 1'b0, 1);
        check("t6_drain_overrun", error, 1);
        ack(2);
        check("t6_third_word", out_data, 32'h00000003);
        wb_rst_i = 1'b1;
        tick(1);
        check("t6_rst_out_valid", out_valid, 0);
        check("t6_rst_busy", busy, 0);
        check("t6_rst_error", error, 0);
        check("t6_rst_res_ready", res_ready, 0);
        wb_rst_i = 1'b0;
        tick(2);

        check("sb_cmd_left", exp_cmd.size(), 0);
        check("sb_out_left", exp_out.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/cmd_assembler.md
Name: cmd_assembler

Overview:
Sits directly downstream of the wishbone slave controller. Consumes its 32-bit write words (input_ready/wishbone_data, config_en) and assembles a header plus operand words into one command for the enclave compute core. It then collects the core's result words and presents them back to the controller (output_ready/wishbone_output) one per host read.

Parameters:
DATA_W, 32, word width of all data paths
MAX_OPERANDS, 8, operand buffer depth (words)
MAX_RESULTS, 4, result buffer depth (words)
OPCODE_W, 8, opcode field width

Ports:
wb_clk_i  in  1  clock
wb_rst_i  in  1  reset: synchronous, active-high
in_valid  in  1  word strobe from controller input_ready; may stay high several cycles
in_data  in  DATA_W  word from controller wishbone_data
config_en  in  1  qualifies the current word as a header
op_valid  out  1  command available to core
op_code  out  OPCODE_W  command opcode
op_count  out  4  number of valid operand words
op_operands  out  MAX_OPERANDS*DATA_W  operand words; word i at bits [i*DATA_W +: DATA_W]
op_ready  in  1  core accepts command
res_valid  in  1  core result word valid
res_data  in  DATA_W  core result word
res_ready  out  1  result word accepted
out_valid  out  1  to controller output_ready
out_data  out  DATA_W  to controller wishbone_output
out_ack  in  1  host consumed out_data (one pulse per read)
busy  out  1  state != IDLE
error  out  1  sticky protocol error

Behaviour:
- Reset values: all outputs 0; state IDLE; buffers and counters 0.
- Word accept: only on the rising edge of in_valid (in_valid=1, registered previous in_valid=0); in_data and config_en are sampled in that cycle. A held in_valid counts as one word.
- Header fields: [31:24] opcode, [19:16] n = operand count, [11:8] m = result count.
- A header is valid when 1<=n<=MAX_OPERANDS and 1<=m<=MAX_RESULTS.
- IDLE:
  - Accepted word with config_en=1 and valid header: latch opcode/n/m, clear error, go to COLLECT.
  - Header with invalid n or m: set error, stay in IDLE.
  - Accepted word with config_en=0: drop it, set error.
- COLLECT:
  - Each accepted word with config_en=0 is written to operand slot idx, then idx++.
  - The word that makes idx==n moves the FSM to ISSUE on the next cycle.
  - Accepted word with config_en=1: abort the current command, set error, re-decode the word as a new header (same rules as IDLE, with a fresh idx=0).
- ISSUE: op_valid=1 with stable op_code/op_count/op_operands until the cycle op_valid&op_ready, then go to WAIT_RES.
  - Operand slots >= n are driven to 0.
- WAIT_RES: res_ready=1. Each res_valid stores res_data into result slot ridx, ridx++. When ridx reaches m, go to DRAIN.
- DRAIN:
  - out_valid=1; out_data = result slot oidx.
  - out_ack advances oidx. out_ack on the last word (oidx==m-1): go to IDLE and drop out_valid in the next cycle.
  - out_ack while out_valid=0 is ignored.
- Accepted words during ISSUE, WAIT_RES or DRAIN: dropped and error set (overrun). The command in flight is unaffected.
- error: sticky. Cleared only by the next valid header or by reset.
- Simultaneous header error and overrun: error is simply set; there is no priority issue.
- Reset mid-operation: returns to IDLE within one cycle. Any partial command is discarded with no op_valid glitch.
- Latency: ISSUE begins 1 cycle after the last operand word is accepted. out_valid rises 1 cycle after the m-th res_valid.

Decomposition:
- Shared package enclave_cmd_pkg holds:
  - the state enum (IDLE, COLLECT, ISSUE, WAIT_RES, DRAIN);
  - header field bit positions;
  - MAX_OPERANDS/MAX_RESULTS defaults.
- One sub-module, res_buffer: an m-deep write-then-read word store with write index, read index and a full flag, reused for the result path.

Test Plan:
- Basic command: header 0x0A020100 (op 0x0A, n=2, m=1), operands 0x11111111 and 0x22222222 -> op_valid with op_count=2, slot0=0x11111111, slot1=0x22222222, slots 2-7 = 0. Core returns 0xDEADBEEF -> out_valid, out_data=0xDEADBEEF; out_ack -> IDLE, busy=0.
- in_valid held high for 3 cycles per word -> each word counted once; the command completes after exactly n+1 rising edges.
- Invalid headers n=0, then n=9, then m=5 -> error=1, state stays IDLE, no op_valid. A following valid header -> error=0.
- New header after 1 of 3 operands -> error=1, the first command never issues, and the second command completes normally with its own operands.
- op_ready held low for 10 cycles -> op_valid and all op_* fields stable throughout. Extra word written during ISSUE -> error=1, command unchanged.
- m=4 results 1,2,3,4 -> out_data sequence 1,2,3,4 across four out_ack pulses. Reset asserted after the 2nd out_ack -> next cycle out_valid=0, busy=0, error=0.
